// File: rtl/adder_response_monitor_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_response_monitor_if : stimulus/response bundle for the monitor  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface adder_response_monitor_if #(
  parameter int CNT_W  = 8,
  parameter int MISR_W = 16
);
  logic              start;
  logic              vld;
  logic [3:0]        a;
  logic [3:0]        b;
  logic              cin;
  logic [4:0]        obs;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_cnt;
  logic              first_err_vld;
  logic [CNT_W-1:0]  first_err_idx;
  logic              trojan_flag;
  logic [MISR_W-1:0] signature;

  modport master (
    output start, vld, a, b, cin, obs,
    input  busy, done, err_cnt, first_err_vld, first_err_idx, trojan_flag, signature
  );

  modport slave (
    input  start, vld, a, b, cin, obs,
    output busy, done, err_cnt, first_err_vld, first_err_idx, trojan_flag, signature
  );
endinterface
`default_nettype wire

// File: rtl/adder_response_monitor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | adder_response_monitor : checks a 4-bit adder per session, counts     |
// | mismatches; optional MISR under ADDER_MON_MISR_EN.     Rev 1.0        |
// +----------------------------------------------------------------------+
module adder_response_monitor #(
  parameter int                N_VEC     = 16,
  parameter int                CNT_W     = 8,
  parameter int                MISR_W    = 16,
  parameter logic [MISR_W-1:0] MISR_POLY = 16'h100B
) (
  input  logic                    clk,
  input  logic                    rst,
  adder_response_monitor_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_N_VEC = CNT_W'(N_VEC);
  localparam logic [CNT_W-1:0] c_LAST  = CNT_W'(N_VEC - 1);

  state_t           r_state;
  logic [CNT_W-1:0] r_vec_idx;
  logic             r_s1_vld;
  logic [3:0]       r_s1_a;
  logic [3:0]       r_s1_b;
  logic             r_s1_cin;
  logic [4:0]       r_s1_obs;
  logic [CNT_W-1:0] r_s1_idx;
  logic [CNT_W-1:0] r_err_cnt;
  logic             r_first_vld;
  logic [CNT_W-1:0] r_first_idx;
  logic             r_busy;
  logic             r_done;
  logic             r_trojan;

  logic             w_sess_start;
  logic             w_accept;
  logic [4:0]       w_expected;
  logic             w_mismatch;
  logic [CNT_W-1:0] w_err_cnt_nxt;
  logic             w_last;

  assign w_sess_start  = (r_state != S_RUN) && bus.start;
  assign w_accept      = (r_state == S_RUN) && bus.vld && (r_vec_idx != c_N_VEC);
  assign w_expected    = {1'b0, r_s1_a} + {1'b0, r_s1_b} + {4'b0, r_s1_cin};
  assign w_mismatch    = r_s1_vld && (w_expected != r_s1_obs);
  assign w_err_cnt_nxt = (w_mismatch && !(&r_err_cnt)) ? r_err_cnt + CNT_W'(1) : r_err_cnt;
  assign w_last        = r_s1_vld && (r_s1_idx == c_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_vec_idx   <= '0;
      r_s1_vld    <= 1'b0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_cin    <= 1'b0;
      r_s1_obs    <= '0;
      r_s1_idx    <= '0;
      r_err_cnt   <= '0;
      r_first_vld <= 1'b0;
      r_first_idx <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_trojan    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state     <= S_RUN;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_trojan    <= 1'b0;
            r_err_cnt   <= '0;
            r_first_vld <= 1'b0;
            r_first_idx <= '0;
            r_vec_idx   <= '0;
            r_s1_vld    <= 1'b0;
          end
        end
        S_RUN: begin
          // Stage 1: capture the applied vector and its index
          r_s1_vld <= w_accept;
          if (w_accept) begin
            r_s1_a    <= bus.a;
            r_s1_b    <= bus.b;
            r_s1_cin  <= bus.cin;
            r_s1_obs  <= bus.obs;
            r_s1_idx  <= r_vec_idx;
            r_vec_idx <= r_vec_idx + CNT_W'(1);
          end
          // Stage 2: compare against the golden sum
          if (r_s1_vld) begin
            r_err_cnt <= w_err_cnt_nxt;
            if (w_mismatch && !r_first_vld) begin
              r_first_vld <= 1'b1;
              r_first_idx <= r_s1_idx;
            end
            if (w_last) begin
              r_state  <= S_DONE;
              r_busy   <= 1'b0;
              r_done   <= 1'b1;
              r_trojan <= (w_err_cnt_nxt != '0);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.err_cnt       = r_err_cnt;
  assign bus.first_err_vld = r_first_vld;
  assign bus.first_err_idx = r_first_idx;
  assign bus.trojan_flag   = r_trojan;

`ifdef ADDER_MON_MISR_EN
  logic [MISR_W-1:0] r_sig;
  logic [MISR_W-1:0] w_sig_nxt;

  assign w_sig_nxt = {r_sig[MISR_W-2:0], 1'b0}
                   ^ (r_sig[MISR_W-1] ? MISR_POLY : '0)
                   ^ MISR_W'(r_s1_obs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sig <= '0;
    end else if (w_sess_start) begin
      r_sig <= '1;
    end else if ((r_state == S_RUN) && r_s1_vld) begin
      r_sig <= w_sig_nxt;
    end
  end

  assign bus.signature = r_sig;
`else
  logic w_unused_poly;
  assign w_unused_poly = ^MISR_POLY;
  assign bus.signature = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_response_monitor.sv
`default_nettype none
// Bench for adder_response_monitor: a 16-vector/8-bit instance and a
// 7-vector/3-bit instance checked against a session-level model.
module tb_adder_response_monitor;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adder_response_monitor_if #(.CNT_W(8), .MISR_W(16)) ifa ();
  adder_response_monitor_if #(.CNT_W(3), .MISR_W(16)) ifb ();

  adder_response_monitor #(.N_VEC(16), .CNT_W(8), .MISR_W(16), .MISR_POLY(16'h100B))
    u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  adder_response_monitor #(.N_VEC(7), .CNT_W(3), .MISR_W(16), .MISR_POLY(16'h100B))
    u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Session-level model: mode 0=idle, 1=running, 2=finished
  int          nvec [2] = '{16, 7};
  int          emax [2] = '{255, 7};
  int          m_mode[2], m_idx[2], m_err[2], m_fidx[2];
  bit          m_fvld[2], m_pend[2];
  int          p_a[2], p_b[2], p_ci[2], p_ob[2], p_idx[2];
  logic [15:0] m_sig[2];

  task automatic model_reset(input int d);
    m_mode[d] = 0; m_idx[d] = 0; m_err[d] = 0; m_fidx[d] = 0;
    m_fvld[d] = 0; m_pend[d] = 0; m_sig[d] = '0;
  endtask

  task automatic model_step(input int d, input logic st, input logic v, input logic [3:0] a,
                            input logic [3:0] b, input logic ci, input logic [4:0] ob);
    int old_mode;
    old_mode = m_mode[d];
    if (m_pend[d]) begin
      if (p_a[d] + p_b[d] + p_ci[d] != p_ob[d]) begin
        m_err[d] = (m_err[d] < emax[d]) ? m_err[d] + 1 : m_err[d];
        if (!m_fvld[d]) begin
          m_fvld[d] = 1;
          m_fidx[d] = p_idx[d];
        end
      end
`ifdef ADDER_MON_MISR_EN
      m_sig[d] = {m_sig[d][14:0], 1'b0} ^ (m_sig[d][15] ? 16'h100B : 16'h0) ^ 16'(p_ob[d]);
`endif
      if (p_idx[d] == nvec[d] - 1) m_mode[d] = 2;
      m_pend[d] = 0;
    end
    if (old_mode != 1 && st) begin
      m_mode[d] = 1; m_idx[d] = 0; m_err[d] = 0; m_fvld[d] = 0; m_fidx[d] = 0;
`ifdef ADDER_MON_MISR_EN
      m_sig[d] = '1;
`endif
    end else if (old_mode == 1 && v && m_idx[d] < nvec[d]) begin
      m_pend[d] = 1;
      p_a[d] = int'(a); p_b[d] = int'(b); p_ci[d] = int'(ci); p_ob[d] = int'(ob);
      p_idx[d] = m_idx[d];
      m_idx[d]++;
    end
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        model_reset(0);
        model_reset(1);
      end else begin
        model_step(0, ifa.start, ifa.vld, ifa.a, ifa.b, ifa.cin, ifa.obs);
        model_step(1, ifb.start, ifb.vld, ifb.a, ifb.b, ifb.cin, ifb.obs);
      end
    end
  end

  task automatic cmp_all(input int d, input logic busy, input logic done, input logic [7:0] err,
                         input logic fvld, input logic [7:0] fidx, input logic troj,
                         input logic [15:0] sig);
    chk($sformatf("dut%0d.busy", d), 32'(busy), 32'(m_mode[d] == 1));
    chk($sformatf("dut%0d.done", d), 32'(done), 32'(m_mode[d] == 2));
    chk($sformatf("dut%0d.err_cnt", d), 32'(err), 32'(m_err[d]));
    chk($sformatf("dut%0d.first_err_vld", d), 32'(fvld), 32'(m_fvld[d]));
    chk($sformatf("dut%0d.first_err_idx", d), 32'(fidx), 32'(m_fidx[d]));
    chk($sformatf("dut%0d.trojan", d), 32'(troj), 32'(m_mode[d] == 2 && m_err[d] != 0));
    chk($sformatf("dut%0d.signature", d), 32'(sig), 32'(m_sig[d]));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cmp_all(0, ifa.busy, ifa.done, ifa.err_cnt, ifa.first_err_vld, ifa.first_err_idx,
              ifa.trojan_flag, ifa.signature);
      cmp_all(1, ifb.busy, ifb.done, 8'(ifb.err_cnt), ifb.first_err_vld,
              8'(ifb.first_err_idx), ifb.trojan_flag, ifb.signature);
    end
  end

`ifdef ADDER_MON_MISR_EN
  function automatic logic [15:0] misr_clean(input int n);
    logic [15:0] s;
    int          o;
    s = '1;
    for (int i = 0; i < n; i++) begin
      o = i + (15 - i) + (i % 2);
      s = {s[14:0], 1'b0} ^ (s[15] ? 16'h100B : 16'h0) ^ 16'(o);
    end
    return s;
  endfunction
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_a();
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
  endtask

  task automatic start_b();
    ifb.start = 1'b1; tick(); ifb.start = 1'b0;
  endtask

  task automatic send_a(input int i, input logic [4:0] flip);
    ifa.a = 4'(i); ifa.b = 4'(15 - i); ifa.cin = 1'(i % 2);
    ifa.obs = 5'(i + (15 - i) + (i % 2)) ^ flip;
    ifa.vld = 1'b1; tick(); ifa.vld = 1'b0;
  endtask

  task automatic send_b(input int i, input logic [4:0] flip);
    ifb.a = 4'(i); ifb.b = 4'(15 - i); ifb.cin = 1'(i % 2);
    ifb.obs = 5'(i + (15 - i) + (i % 2)) ^ flip;
    ifb.vld = 1'b1; tick(); ifb.vld = 1'b0;
  endtask

  task automatic chk_sig_clean(input string name, input logic [15:0] got, input int n);
`ifdef ADDER_MON_MISR_EN
    chk(name, 32'(got), 32'(misr_clean(n)));
`else
    chk(name, 32'(got), 32'h0);
    if (n < 0) $display("unreachable");
`endif
  endtask

  initial begin
    ifa.start = 0; ifa.vld = 0; ifa.a = 0; ifa.b = 0; ifa.cin = 0; ifa.obs = 0;
    ifb.start = 0; ifb.vld = 0; ifb.a = 0; ifb.b = 0; ifb.cin = 0; ifb.obs = 0;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", 32'(ifa.busy), 0);
    chk("reset_err", 32'(ifa.err_cnt), 0);
    chk("reset_sig", 32'(ifa.signature), 0);

    // Clean session
    start_a();
    chk("busy_rise", 32'(ifa.busy), 1);
    for (int i = 0; i < 16; i++) send_a(i, 5'b0);
    chk("done_not_yet", 32'(ifa.done), 0);
    tick();
    chk("clean_done", 32'(ifa.done), 1);
    chk("clean_busy", 32'(ifa.busy), 0);
    chk("clean_err", 32'(ifa.err_cnt), 0);
    chk("clean_trojan", 32'(ifa.trojan_flag), 0);
    chk_sig_clean("clean_sig", ifa.signature, 16);

    // Faulty session: s1 flipped on vectors 5 and 9
    start_a();
    for (int i = 0; i < 16; i++) send_a(i, (i == 5 || i == 9) ? 5'b00010 : 5'b0);
    tick();
    chk("fault_err", 32'(ifa.err_cnt), 2);
    chk("fault_fidx", 32'(ifa.first_err_idx), 5);
    chk("fault_fvld", 32'(ifa.first_err_vld), 1);
    chk("fault_trojan", 32'(ifa.trojan_flag), 1);

    // Handshake: stray vld in DONE, gaps, extras after the 16th
    send_a(2, 5'b00001);
    send_a(3, 5'b00001);
    start_a();
    for (int i = 0; i < 16; i++) begin
      send_a(i, 5'b0);
      if (i % 2 == 1) tick();
    end
    for (int i = 0; i < 3; i++) send_a(i, 5'b00100);
    tick();
    chk("hs_done", 32'(ifa.done), 1);
    chk("hs_err", 32'(ifa.err_cnt), 0);
    chk("hs_fvld", 32'(ifa.first_err_vld), 0);
    chk_sig_clean("hs_sig", ifa.signature, 16);

    // Reset mid-run after vector 7, then restart with start+vld together
    start_a();
    for (int i = 0; i < 7; i++) send_a(i, (i == 3) ? 5'b00010 : 5'b0);
    rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(ifa.busy), 0);
    chk("midrst_err", 32'(ifa.err_cnt), 0);
    chk("midrst_fvld", 32'(ifa.first_err_vld), 0);
    chk("midrst_sig", 32'(ifa.signature), 0);
    tick(); tick();
    rst = 1'b0;
    ifa.start = 1'b1;
    ifa.a = 4'd1; ifa.b = 4'd1; ifa.cin = 1'b0; ifa.obs = 5'd7; ifa.vld = 1'b1;
    tick();
    ifa.start = 1'b0; ifa.vld = 1'b0;
    for (int i = 0; i < 16; i++) send_a(i, 5'b0);
    tick();
    chk("restart_done", 32'(ifa.done), 1);
    chk("restart_err", 32'(ifa.err_cnt), 0);
    chk("restart_fvld", 32'(ifa.first_err_vld), 0);
    chk_sig_clean("restart_sig", ifa.signature, 16);

    // Saturation on the 3-bit instance
    start_b();
    for (int i = 0; i < 7; i++) send_b(i, 5'b0);
    tick();
    chk("b_clean_err", 32'(ifb.err_cnt), 0);
    chk_sig_clean("b_clean_sig", ifb.signature, 7);
    start_b();
    for (int i = 0; i < 9; i++) send_b(i % 7, 5'b00001);
    tick();
    chk("b_sat_err", 32'(ifb.err_cnt), 7);
    chk("b_sat_fidx", 32'(ifb.first_err_idx), 0);
    chk("b_sat_trojan", 32'(ifb.trojan_flag), 1);
`ifdef ADDER_MON_MISR_EN
    chk("b_sat_sig_differs", 32'(ifb.signature != misr_clean(7)), 1);
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
